mem_arbiter: RTL and testbench

- Shares the single physical-memory cacheline port between the I-cache and D-cache of the pipelined LC-3b.
- Sits between both L1 caches and pmem. Latches one request at grant and holds it stable on pmem until pmem_resp, then returns the response to the owner.
- D-cache has priority. A starvation counter forces an I-cache grant after STARVE_LIMIT consecutive D grants while I is waiting.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b types used by the memory hierarchy, including the
// arbiter state encoding and line-alignment helper.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cline;

    localparam int LC3B_LINE_OFFSET_BITS = 4;

    localparam lc3b_word LC3B_LINE_MASK = lc3b_word'(16'hFFFF << LC3B_LINE_OFFSET_BITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_arb_state;

    function automatic lc3b_word line_align(input lc3b_word addr);
        return addr & LC3B_LINE_MASK;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single pmem cacheline port between I-cache and D-cache.
// D has priority; a starvation counter forces an I grant after STARVE_LIMIT D grants.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_read,
    input  lc3b_word    i_address,
    output lc3b_cline   i_rdata,
    output logic        i_resp,

    input  logic        d_read,
    input  logic        d_write,
    input  lc3b_word    d_address,
    input  lc3b_cline   d_wdata,
    output lc3b_cline   d_rdata,
    output logic        d_resp,

    output logic        pmem_read,
    output logic        pmem_write,
    output lc3b_word    pmem_address,
    output lc3b_cline   pmem_wdata,
    input  lc3b_cline   pmem_rdata,
    input  logic        pmem_resp
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    lc3b_arb_state state;
    lc3b_arb_state state_next;
    logic [3:0]    starve_cnt;

    logic i_pending;
    logic d_pending;
    logic grant_i;
    logic grant_d;
    logic done;

    assign i_pending = i_read;
    assign d_pending = d_read | d_write;

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                // I only wins a contested cycle once D has used up its allowance.
                if (i_pending && (!d_pending || starve_cnt == STARVE_MAX)) begin
                    grant_i    = 1'b1;
                    state_next = SERVE_I;
                end else if (d_pending) begin
                    grant_d    = 1'b1;
                    state_next = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && i_read && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Request is captured once at grant; requester-side changes afterwards are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else if (grant_i) begin
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= line_align(i_address);
        end else if (grant_d) begin
            pmem_read    <= ~d_write;
            pmem_write   <= d_write;
            pmem_address <= line_align(d_address);
            pmem_wdata   <= d_wdata;
        end else if (done) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
        end
    end

    assign i_resp  = (state == SERVE_I) & pmem_resp;
    assign d_resp  = (state == SERVE_D) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    strobes_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(pmem_read && pmem_write));

    strobe_implies_busy: assert property (@(posedge clk) disable iff (reset)
        (pmem_read || pmem_write) |-> (state != IDLE));

    starve_bounded: assert property (@(posedge clk) disable iff (reset)
        starve_cnt <= STARVE_MAX);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic against a cycle-level rule model and a line-memory scoreboard.
module tb_mem_arbiter;
    import lc3b_types::*;

    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_read;
    logic [15:0]  i_address;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_address;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Line memory behind pmem; unwritten lines have an address-derived pattern.
    logic [127:0] mem [int];

    function automatic logic [127:0] mem_rd(input logic [15:0] a);
        int idx;
        idx = int'(a[15:4]);
        if (mem.exists(idx)) return mem[idx];
        return {4{(32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0000}};
    endfunction

    // Rule model: who owns pmem, what was captured at grant, starvation tally.
    bit           m_valid = 0;
    int           m_owner = 0;   // 0 none, 1 I-cache, 2 D-cache
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    bit           m_wr;
    int           m_starve;
    bit           ip, dp;

    bit rand_on  = 0;
    bit rand_new = 0;
    bit i_done   = 0;
    bit d_done   = 0;
    int i_dgr    = 0;
    bit grant_i_pend  = 0;
    bit prev_strobe   = 0;
    bit prev_i_read   = 0;
    int i_wait = 0;
    int d_wait = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pmem_read", pmem_read, (m_owner == 1) || (m_owner == 2 && !m_wr));
            chk("pmem_write", pmem_write, m_owner == 2 && m_wr);
            chk("pmem_address", pmem_address, m_addr);
            if (m_owner == 2) chk("pmem_wdata", pmem_wdata, m_wdata);
            chk("i_resp", i_resp, (m_owner == 1) && pmem_resp);
            chk("d_resp", d_resp, (m_owner == 2) && pmem_resp);
            if (i_resp) chk("i_rdata", i_rdata, pmem_rdata);
            if (d_resp) chk("d_rdata", d_rdata, pmem_rdata);
            chk("starve_cnt", dut.starve_cnt, m_starve);
            chk("strobe_excl", pmem_read & pmem_write, 1'b0);
        end

        if (d_read && d_write) flag("illegal_d_read_and_write");

        if (i_read) i_wait++; else i_wait = 0;
        if (d_read | d_write) d_wait++; else d_wait = 0;
        if (i_wait == 400) flag("i_request_timeout");
        if (d_wait == 400) flag("d_request_timeout");

        if (rand_on) begin
            if ((pmem_read | pmem_write) && !prev_strobe) grant_i_pend = prev_i_read;
            if (i_resp) begin
                if (!i_read) flag("i_resp_without_request");
                else begin
                    chk("i_line_data", i_rdata, mem_rd(i_address));
                    chk("i_starve_bound", i_dgr <= LIMIT, 1'b1);
                    i_done = 1;
                    i_dgr  = 0;
                end
            end
            if (d_resp) begin
                if (!(d_read | d_write)) flag("d_resp_without_request");
                else begin
                    if (d_write) chk("d_wb_data", mem_rd(d_address), d_wdata);
                    else         chk("d_line_data", d_rdata, mem_rd(d_address));
                    d_done = 1;
                    if (grant_i_pend) i_dgr++;
                end
            end
        end
        prev_strobe = pmem_read | pmem_write;
        prev_i_read = i_read;

        if (reset) begin
            m_valid  = 1;
            m_owner  = 0;
            m_starve = 0;
            m_addr   = '0;
            m_wdata  = '0;
            m_wr     = 0;
        end else if (m_valid) begin
            if (m_owner != 0) begin
                if (pmem_resp) m_owner = 0;
            end else begin
                ip = i_read;
                dp = d_read | d_write;
                if (ip && (!dp || m_starve == LIMIT)) begin
                    m_owner  = 1;
                    m_addr   = i_address & 16'hFFF0;
                    m_wr     = 0;
                    m_starve = 0;
                end else if (dp) begin
                    m_owner = 2;
                    m_addr  = d_address & 16'hFFF0;
                    m_wdata = d_wdata;
                    m_wr    = d_write;
                    if (ip && m_starve < LIMIT) m_starve++;
                end
            end
        end
    end

    bit rsp_busy = 0;
    int rsp_cnt  = 0;

    task automatic responder();
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (pmem_read | pmem_write) begin
            if (!rsp_busy) begin
                rsp_busy = 1;
                rsp_cnt  = int'($urandom_range(0, 6));
            end
            if (rsp_cnt == 0) begin
                pmem_resp = 1'b1;
                rsp_busy  = 0;
                if (pmem_read) pmem_rdata = mem_rd(pmem_address);
                else           mem[int'(pmem_address[15:4])] = pmem_wdata;
            end else begin
                rsp_cnt--;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            pmem_resp = 1'b1;
        end
    endtask

    task automatic agents();
        if (i_read) begin
            if (i_done) begin
                i_read = 1'b0;
                i_done = 0;
            end
        end else if (rand_new && $urandom_range(0, 3) == 0) begin
            i_read    = 1'b1;
            i_address = 16'($urandom_range(0, 511));
        end
        if (d_read | d_write) begin
            if (d_done) begin
                d_read  = 1'b0;
                d_write = 1'b0;
                d_done  = 0;
            end
        end else if (rand_new && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 1) d_write = 1'b1;
            else                           d_read  = 1'b1;
            d_address = 16'($urandom_range(0, 511));
            d_wdata   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_on) begin
            responder();
            agents();
        end
    endtask

    int n_grants;
    int ord;
    int idle_cnt;
    int cnt_before_i;
    int cnt_after_i;
    bit got_i;

    initial begin
        reset = 1'b1; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, 16'h0);
        chk("rst_pmem_wdata", pmem_wdata, 128'h0);
        chk("rst_state", dut.state, IDLE);
        chk("rst_starve", dut.starve_cnt, 4'd0);

        // I-only read, response five cycles after the strobe
        step();
        reset = 1'b0; i_read = 1'b1; i_address = 16'h1234;
        step();
        @(negedge clk);
        chk("t1_pmem_read", pmem_read, 1'b1);
        chk("t1_pmem_address", pmem_address, 16'h1230);
        repeat (4) step();
        step();
        pmem_resp = 1'b1; pmem_rdata = {16{8'hA5}};
        @(negedge clk);
        chk("t1_i_resp", i_resp, 1'b1);
        chk("t1_i_rdata", i_rdata, {16{8'hA5}});
        chk("t1_d_resp", d_resp, 1'b0);
        step();
        pmem_resp = 1'b0; i_read = 1'b0;
        @(negedge clk);
        chk("t1_strobe_off", pmem_read, 1'b0);

        // D writeback with the requester changing address mid-flight
        step();
        d_write = 1'b1; d_address = 16'h8000; d_wdata = {8{16'hDEAD}};
        step();
        @(negedge clk);
        chk("t2_pmem_write", pmem_write, 1'b1);
        chk("t2_pmem_read", pmem_read, 1'b0);
        chk("t2_pmem_address", pmem_address, 16'h8000);
        chk("t2_pmem_wdata", pmem_wdata, {8{16'hDEAD}});
        step();
        d_address = 16'h8ABC; d_wdata = '0;
        step();
        @(negedge clk);
        chk("t2_addr_hold", pmem_address, 16'h8000);
        chk("t2_wdata_hold", pmem_wdata, {8{16'hDEAD}});
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("t2_d_resp", d_resp, 1'b1);
        chk("t2_i_resp", i_resp, 1'b0);
        step();
        pmem_resp = 1'b0; d_write = 1'b0; d_address = '0;

        // Both held: D wins LIMIT times, then I is forced
        step();
        i_read = 1'b1; i_address = 16'h0104; d_read = 1'b1; d_address = 16'h0208;
        n_grants = 0; ord = 0; idle_cnt = -1; cnt_before_i = -1; cnt_after_i = -1; got_i = 0;
        for (int c = 0; c < 40 && !got_i; c++) begin
            step();
            pmem_resp  = pmem_read | pmem_write;
            pmem_rdata = {4{$urandom}};
            @(negedge clk);
            if (pmem_read) begin
                if (pmem_address == 16'h0100) begin
                    ord = ord | (1 << n_grants);
                    got_i = 1;
                    cnt_before_i = idle_cnt;
                    cnt_after_i  = int'(dut.starve_cnt);
                end
                n_grants++;
            end else begin
                idle_cnt = int'(dut.starve_cnt);
            end
        end
        chk("t3_grant_count", n_grants, 5);
        chk("t3_grant_order", ord, 16);
        chk("t3_starve_before_i", cnt_before_i, 4);
        chk("t3_starve_after_i", cnt_after_i, 0);
        step();
        pmem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;

        // Spurious resp in IDLE, zero-delay completion, request arriving at completion
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("t4_spur_i_resp", i_resp, 1'b0);
        chk("t4_spur_d_resp", d_resp, 1'b0);
        step();
        pmem_resp = 1'b0; i_read = 1'b1; i_address = 16'h2220;
        step();
        pmem_resp = 1'b1; pmem_rdata = {8{16'h1357}}; d_read = 1'b1; d_address = 16'h3330;
        @(negedge clk);
        chk("t4_i_resp", i_resp, 1'b1);
        chk("t4_d_resp_early", d_resp, 1'b0);
        step();
        pmem_resp = 1'b0; i_read = 1'b0;
        @(negedge clk);
        chk("t4_gap_read", pmem_read, 1'b0);
        chk("t4_gap_state", dut.state, IDLE);
        step();
        @(negedge clk);
        chk("t4_d_grant", pmem_read, 1'b1);
        chk("t4_d_address", pmem_address, 16'h3330);
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("t4_d_resp", d_resp, 1'b1);
        step();
        pmem_resp = 1'b0; d_read = 1'b0;

        // Reset two cycles into a D read; a late resp must be ignored
        step();
        d_read = 1'b1; d_address = 16'h3000;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; d_read = 1'b0;
        @(negedge clk);
        chk("t5_pmem_read", pmem_read, 1'b0);
        chk("t5_state", dut.state, IDLE);
        step();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("t5_late_d_resp", d_resp, 1'b0);
        chk("t5_late_i_resp", i_resp, 1'b0);
        step();
        pmem_resp = 1'b0;

        // Randomized traffic
        step();
        i_done = 0; d_done = 0; i_dgr = 0; rsp_busy = 0;
        rand_on = 1; rand_new = 1;
        repeat (10000) step();
        rand_new = 0;
        for (int c = 0; c < 600 && (i_read || d_read || d_write); c++) step();
        if (i_read || d_read || d_write) flag("drain_timeout");
        rand_on = 0;
        step();
        pmem_resp = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
